microwave_timer_ctrl: RTL and testbench
=======================================

// Module: microwave_timer_ctrl
// PURPOSE
//  Parametrised microwave cook-timer controller, next generation of the microwave block.
//  - Takes a one-hot decimal keypad plus active-low start/stop/clear buttons and a door switch.
//  - Holds an MM:SS BCD countdown with a configurable number of minute digits.
//  - Drives one 7-segment display per digit, with leading-zero blanking, and the magnetron enable.
//  - Sits between the debounced front-panel inputs and the display/magnetron drivers.
// PARAMETERS
//  CLK_HZ      100  clk_100Hz cycles per countdown second (prescaler modulus, >=2)
//  MIN_DIGITS  1    number of BCD minute digits (1..2); total digits N = MIN_DIGITS+2
//  POWER_WIN_S 10   duty window in seconds for power-level cycling (POWER_LEVEL_EN only)
// PORTS
//  clk_100Hz      in   1            system clock, rising edge
//  reset          in   1            synchronous, active-high
//  keypad         in   10           one-hot digit keys, bit d = digit d
//  startn         in   1            start button, active low
//  stopn          in   1            stop/pause button, active low
//  clearn         in   1            clear button, active low
//  door_closed    in   1            1 = door closed
//  power_key      in   1            power-set key, active high; ignored without POWER_LEVEL_EN
//  sec_ones_segs  out  7            seconds ones, active-high {g,f,e,d,c,b,a}
//  sec_tens_segs  out  7            seconds tens
//  min_segs       out  7*MIN_DIGITS minutes; [6:0] = minutes ones
//  blank_digit    out  N            bit i=1: digit i blanked (segs forced 0); bit0 = sec ones
//  mag_on         out  1            magnetron enable
//  cook_state     out  3            IDLE=0 SET=1 COOK=2 PAUSE=3 DONE=4
//  done_pulse     out  1            one-cycle pulse when the countdown reaches zero
// BEHAVIOUR
//  - Reset: digits 0, cook_state IDLE, mag_on 0, done_pulse 0, prescaler 0.
//    Reset values: sec_ones_segs 7'h3F, other segs 0, blank_digit = {N-1{1'b1},1'b0}.
//  - Inputs are registered once. Buttons and power_key act on their registered active edge.
//  - A key is accepted only when keypad becomes exactly one-hot after having been all-zero.
//    Multi-bit or held keypad values are ignored.
//  - Latency: an input change before edge t is registered at t; the effect is visible after edge t+1.
//  - Event priority: reset > clearn > door open > stopn > startn > power_key/keypad.
//  - IDLE/SET, key accepted: digits shift left one position, new key enters sec ones,
//    the top digit is discarded, state becomes SET.
//  - startn in IDLE/SET: goes to COOK only if time != 0 and door_closed. Otherwise ignored.
//    The prescaler is zeroed on entry.
//  - COOK: prescaler counts 0..CLK_HZ-1. On wrap, time decrements by one second (BCD).
//    - The seconds tens digit entered may be 6..9; it decrements like any other BCD digit.
//    - Borrow from minutes when seconds reach 00: seconds reload to 59, the minute digit
//      decrements, and minutes ones 0 borrows from minutes tens.
//    - Keypad and startn are ignored while in COOK.
//  - COOK stop conditions:
//    - stopn or door open -> PAUSE; the prescaler value is retained.
//    - startn in PAUSE with the door closed -> resumes COOK from the retained prescaler value.
//  - Zero reached: on the decrement to 0:00, state goes to DONE, done_pulse=1 for one cycle,
//    mag_on=0 on the same edge.
//  - DONE: leaves to IDLE on any accepted key, clearn, startn or door open.
//    An accepted key in DONE is discarded.
//  - clearn in any state: digits 0, prescaler 0, state IDLE.
//  - stopn outside COOK: no effect.
//  - mag_on (registered) = state==COOK && door_closed, subject to the power-level gate below.
//  - Blanking: digit i>0 is blanked when it and all higher digits are 0. Sec ones is never blanked.
//    Same rule in every state.
//  - Segment patterns for 0..9 are standard. A digit >9 (not reachable) displays all-off.
// CONFIGURATION
//  POWER_LEVEL_EN defined:
//  - An accepted power_key followed by an accepted key sets power P; key 0 selects P=POWER_WIN_S.
//    That key does not enter time.
//  - Reset/clear sets P=POWER_WIN_S.
//  - In COOK, a seconds counter w runs 0..POWER_WIN_S-1, advancing on each second tick.
//    mag_on = COOK && door_closed && (w < P); w resets on start from IDLE/SET.
//  POWER_LEVEL_EN undefined: power_key is ignored, no P/w logic, mag_on is full-time in COOK.
// TESTING
//  1 reset; keys 1,0,8 -> 1:08, blank_digit=3'b000; startn -> mag_on=1 within 2 cycles;
//    +38*CLK_HZ cycles -> 0:30
//  2 stopn in COOK -> PAUSE, mag_on=0, display holds 0:30;
//    clearn -> IDLE, sec_ones "0", blank_digit=3'b110
//  3 keypad=10'b0010011000 then 10'b1100001001 -> no digit change, state stays IDLE
//  4 keys 2,6, door open, startn -> stays SET, mag_on=0; door close, startn -> COOK;
//    26*CLK_HZ cycles later -> done_pulse=1 once, DONE, mag_on=0
//  5 COOK at 0:10, door open mid-second -> PAUSE in 2 cycles; close + startn ->
//    the next decrement lands at the remaining prescaler count; 0:59 -> borrow from 1:00 correct
//  6 POWER_LEVEL_EN: power_key, key 3, keys 2,0, start ->
//    mag_on high 3*CLK_HZ cycles out of each 10*CLK_HZ cycles

Source files
------------

// File: rtl/microwave_timer_ctrl.sv
// microwave_timer_ctrl: MM:SS BCD cook timer with keypad entry, 7-seg display and magnetron enable; POWER_LEVEL_EN adds power-level duty cycling
module microwave_timer_ctrl #(
  parameter int CLK_HZ      = 100,
  parameter int MIN_DIGITS  = 1,
  parameter int POWER_WIN_S = 10
) (
  input  logic                    clk_100Hz,
  input  logic                    reset,
  input  logic [9:0]              keypad,
  input  logic                    startn,
  input  logic                    stopn,
  input  logic                    clearn,
  input  logic                    door_closed,
  input  logic                    power_key,
  output logic [6:0]              sec_ones_segs,
  output logic [6:0]              sec_tens_segs,
  output logic [7*MIN_DIGITS-1:0] min_segs,
  output logic [MIN_DIGITS+1:0]   blank_digit,
  output logic                    mag_on,
  output logic [2:0]              cook_state,
  output logic                    done_pulse
);
  localparam int N   = MIN_DIGITS + 2;
  localparam int PSW = $clog2(CLK_HZ);
  typedef enum logic [2:0] {IDLE = 3'd0, SET = 3'd1, COOK = 3'd2, PAUSE = 3'd3, DONE = 3'd4} state_t;
  state_t state_q, state_d;
  logic [N-1:0][3:0] dig_q, dig_d, dig_dec, dig_shl;
  logic [PSW-1:0] presc_q, presc_d;
  logic [9:0] key_q, key_p;
  logic [2:0] btn_q, btn_p, btn_ev;
  logic [N-1:0] blank;
  logic door_q, mag_q, mag_d, done_q, done_d;
  logic key_acc, dec_zero, time_nz, borrow, gate, zero_run;
  logic [3:0] key_code;
`ifdef POWER_LEVEL_EN
  localparam int PW = $clog2(POWER_WIN_S + 10);
  logic pwr_q, pwr_p, pwr_ev, pend_q, pend_d;
  logic [PW-1:0] p_q, p_d, w_q, w_d;
  assign pwr_ev = pwr_q && !pwr_p;
`else
  logic unused_power;
  assign unused_power = power_key;
`endif
  assign btn_ev = btn_q & ~btn_p;
  always_ff @(posedge clk_100Hz) begin
    if (reset) begin
      key_q  <= '0;
      key_p  <= '0;
      btn_q  <= '0;
      btn_p  <= '0;
      door_q <= 1'b0;
`ifdef POWER_LEVEL_EN
      pwr_q  <= 1'b0;
      pwr_p  <= 1'b0;
`endif
    end else begin
      key_q  <= keypad;
      key_p  <= key_q;
      btn_q  <= ~{clearn, stopn, startn};
      btn_p  <= btn_q;
      door_q <= door_closed;
`ifdef POWER_LEVEL_EN
      pwr_q  <= power_key;
      pwr_p  <= pwr_q;
`endif
    end
  end
  // BCD countdown: seconds tens reloads to 5, every other digit to 9
  always_comb begin
    key_code = '0;
    for (int d = 0; d < 10; d++) key_code = key_q[d] ? 4'(d) : key_code;
    key_acc = key_q != '0 && (key_q & (key_q - 10'd1)) == '0 && key_p == '0;
    borrow = 1'b1;
    dec_zero = 1'b1;
    for (int i = 0; i < N; i++) begin
      dig_dec[i] = !borrow ? dig_q[i] : dig_q[i] != 4'd0 ? dig_q[i] - 4'd1 : i == 1 ? 4'd5 : 4'd9;
      borrow = borrow && dig_q[i] == 4'd0;
      dec_zero = dec_zero && dig_dec[i] == 4'd0;
    end
    dig_shl = {dig_q[N-2:0], key_code};
    time_nz = dig_q != '0;
  end
  always_comb begin
    state_d = state_q;
    dig_d = dig_q;
    presc_d = presc_q;
    done_d = 1'b0;
`ifdef POWER_LEVEL_EN
    pend_d = pend_q;
    p_d = p_q;
    w_d = w_q;
`endif
    if (btn_ev[2]) begin
      state_d = IDLE;
      dig_d = '0;
      presc_d = '0;
`ifdef POWER_LEVEL_EN
      p_d = PW'(POWER_WIN_S);
      pend_d = 1'b0;
`endif
    end else if (state_q == COOK) begin
      if (!door_q || btn_ev[1]) state_d = PAUSE;
      else if (presc_q == PSW'(CLK_HZ - 1)) begin
        presc_d = '0;
        dig_d = dig_dec;
        state_d = dec_zero ? DONE : COOK;
        done_d = dec_zero;
`ifdef POWER_LEVEL_EN
        w_d = w_q == PW'(POWER_WIN_S - 1) ? '0 : w_q + 1'b1;
`endif
      end else presc_d = presc_q + 1'b1;
    end else if (state_q == PAUSE) state_d = door_q && btn_ev[0] ? COOK : PAUSE;
    else if (state_q == DONE) state_d = !door_q || btn_ev[0] || key_acc ? IDLE : DONE;
    else if (btn_ev[0]) begin
      if (door_q && time_nz) begin
        state_d = COOK;
        presc_d = '0;
`ifdef POWER_LEVEL_EN
        w_d = '0;
`endif
      end
    end
`ifdef POWER_LEVEL_EN
    else if (pwr_ev) pend_d = 1'b1;
    else if (key_acc && pend_q) begin
      p_d = key_code == 4'd0 ? PW'(POWER_WIN_S) : PW'(key_code);
      pend_d = 1'b0;
    end
`endif
    else if (key_acc) begin
      dig_d = dig_shl;
      state_d = SET;
    end
`ifdef POWER_LEVEL_EN
    gate = w_d < p_d;
`else
    gate = 1'b1;
`endif
    mag_d = state_d == COOK && door_q && gate;
  end
  always_ff @(posedge clk_100Hz) begin
    if (reset) begin
      state_q <= IDLE;
      dig_q   <= '0;
      presc_q <= '0;
      mag_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef POWER_LEVEL_EN
      pend_q  <= 1'b0;
      p_q     <= PW'(POWER_WIN_S);
      w_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      presc_q <= presc_d;
      mag_q   <= mag_d;
      done_q  <= done_d;
`ifdef POWER_LEVEL_EN
      pend_q  <= pend_d;
      p_q     <= p_d;
      w_q     <= w_d;
`endif
    end
  end
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction
  // a digit is blanked only while it and every digit above it are zero
  always_comb begin
    zero_run = 1'b1;
    blank = '0;
    for (int i = N - 1; i > 0; i--) begin
      zero_run = zero_run && dig_q[i] == 4'd0;
      blank[i] = zero_run;
    end
    sec_ones_segs = seg7(dig_q[0]);
    sec_tens_segs = blank[1] ? 7'h00 : seg7(dig_q[1]);
    min_segs = '0;
    for (int k = 0; k < MIN_DIGITS; k++) min_segs[7*k +: 7] = blank[k+2] ? 7'h00 : seg7(dig_q[k+2]);
  end
  assign blank_digit = blank;
  assign mag_on = mag_q;
  assign done_pulse = done_q;
  assign cook_state = state_q;
endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// tb_microwave_timer_ctrl: directed self-checking bench for microwave_timer_ctrl
module tb_microwave_timer_ctrl;
  localparam int CLK = 20;
  localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [9:0] keypad = '0;
  logic startn = 1'b1;
  logic stopn = 1'b1;
  logic clearn = 1'b1;
  logic door_closed = 1'b1;
  logic power_key = 1'b0;
  logic [6:0] sec_ones_segs, sec_tens_segs, min_segs;
  logic [2:0] blank_digit;
  logic mag_on, done_pulse;
  logic [2:0] cook_state;
  logic [20:0] disp;
  int total = 0;
  int bad = 0;
  microwave_timer_ctrl #(.CLK_HZ(CLK), .MIN_DIGITS(1), .POWER_WIN_S(10)) dut (
    .clk_100Hz(clk), .reset(reset), .keypad(keypad), .startn(startn), .stopn(stopn),
    .clearn(clearn), .door_closed(door_closed), .power_key(power_key),
    .sec_ones_segs(sec_ones_segs), .sec_tens_segs(sec_tens_segs), .min_segs(min_segs),
    .blank_digit(blank_digit), .mag_on(mag_on), .cook_state(cook_state), .done_pulse(done_pulse)
  );
  always #5 clk = ~clk;
  assign disp = {min_segs, sec_tens_segs, sec_ones_segs};
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press_key(input int d);
    keypad = 10'(1 << d);
    tick(2);
    keypad = '0;
    tick(2);
  endtask
  task automatic pulse_start;
    startn = 1'b0;
    tick(2);
    startn = 1'b1;
  endtask
  task automatic pulse_stop;
    stopn = 1'b0;
    tick(2);
    stopn = 1'b1;
  endtask
  task automatic pulse_clear;
    clearn = 1'b0;
    tick(2);
    clearn = 1'b1;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    total++; if (cook_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", cook_state); end
    total++; if ({mag_on, done_pulse} !== 2'b00) begin bad++; $display("FAIL reset_mag_done: got %b want 00", {mag_on, done_pulse}); end
    total++; if (disp !== {7'h00, 7'h00, 7'h3F}) begin bad++; $display("FAIL reset_segs: got %h want %h", disp, {7'h00, 7'h00, 7'h3F}); end
    total++; if (blank_digit !== 3'b110) begin bad++; $display("FAIL reset_blank: got %b want 110", blank_digit); end
  endtask
  task automatic test_countdown;
    press_key(1);
    press_key(0);
    press_key(8);
    total++; if (disp !== {SEG[1], SEG[0], SEG[8]}) begin bad++; $display("FAIL entry_108: got %h want %h", disp, {SEG[1], SEG[0], SEG[8]}); end
    total++; if (blank_digit !== 3'b000) begin bad++; $display("FAIL entry_blank: got %b want 000", blank_digit); end
    total++; if (cook_state !== 3'd1) begin bad++; $display("FAIL entry_state: got %0d want 1", cook_state); end
    pulse_start;
    total++; if ({cook_state, mag_on} !== {3'd2, 1'b1}) begin bad++; $display("FAIL start_cook: got %0d/%b want 2/1", cook_state, mag_on); end
    tick(38 * CLK - 1);
    total++; if (disp !== {7'h00, SEG[3], SEG[1]}) begin bad++; $display("FAIL count_031: got %h want %h", disp, {7'h00, SEG[3], SEG[1]}); end
    tick(1);
    total++; if (disp !== {7'h00, SEG[3], SEG[0]}) begin bad++; $display("FAIL count_030: got %h want %h", disp, {7'h00, SEG[3], SEG[0]}); end
    total++; if (blank_digit !== 3'b100) begin bad++; $display("FAIL count_blank: got %b want 100", blank_digit); end
  endtask
  task automatic test_stop_clear;
    pulse_stop;
    total++; if ({cook_state, mag_on} !== {3'd3, 1'b0}) begin bad++; $display("FAIL stop_pause: got %0d/%b want 3/0", cook_state, mag_on); end
    tick(2 * CLK);
    total++; if (disp !== {7'h00, SEG[3], SEG[0]}) begin bad++; $display("FAIL pause_hold: got %h want %h", disp, {7'h00, SEG[3], SEG[0]}); end
    pulse_clear;
    total++; if (cook_state !== 3'd0) begin bad++; $display("FAIL clear_state: got %0d want 0", cook_state); end
    total++; if ({blank_digit, sec_ones_segs} !== {3'b110, 7'h3F}) begin bad++; $display("FAIL clear_disp: got %b/%h want 110/3f", blank_digit, sec_ones_segs); end
    pulse_stop;
    total++; if (cook_state !== 3'd0) begin bad++; $display("FAIL stop_idle: got %0d want 0", cook_state); end
  endtask
  task automatic test_bad_keys;
    keypad = 10'b0010011000;
    tick(3);
    keypad = 10'b1100001001;
    tick(3);
    keypad = '0;
    tick(2);
    total++; if ({cook_state, disp} !== {3'd0, 7'h00, 7'h00, 7'h3F}) begin bad++; $display("FAIL multi_key: got %0d/%h want 0/00003f", cook_state, disp); end
    keypad = 10'b0000100000;
    tick(4);
    keypad = 10'b0000010000;
    tick(3);
    keypad = '0;
    tick(2);
    total++; if ({cook_state, disp} !== {3'd1, 7'h00, 7'h00, SEG[5]}) begin bad++; $display("FAIL held_key: got %0d/%h want 1/%h", cook_state, disp, {7'h00, 7'h00, SEG[5]}); end
    pulse_clear;
  endtask
  task automatic test_door_done;
    press_key(2);
    press_key(6);
    total++; if ({blank_digit, disp} !== {3'b100, 7'h00, SEG[2], SEG[6]}) begin bad++; $display("FAIL entry_026: got %b/%h want 100/%h", blank_digit, disp, {7'h00, SEG[2], SEG[6]}); end
    door_closed = 1'b0;
    pulse_start;
    total++; if ({cook_state, mag_on} !== {3'd1, 1'b0}) begin bad++; $display("FAIL door_open_start: got %0d/%b want 1/0", cook_state, mag_on); end
    door_closed = 1'b1;
    tick(2);
    pulse_start;
    total++; if ({cook_state, mag_on} !== {3'd2, 1'b1}) begin bad++; $display("FAIL door_closed_start: got %0d/%b want 2/1", cook_state, mag_on); end
    tick(26 * CLK - 1);
    total++; if ({cook_state, done_pulse, disp} !== {3'd2, 1'b0, 7'h00, 7'h00, SEG[1]}) begin bad++; $display("FAIL before_done: got %0d/%b/%h", cook_state, done_pulse, disp); end
    tick(1);
    total++; if ({cook_state, done_pulse, mag_on} !== {3'd4, 1'b1, 1'b0}) begin bad++; $display("FAIL done_edge: got %0d/%b/%b want 4/1/0", cook_state, done_pulse, mag_on); end
    total++; if (blank_digit !== 3'b110) begin bad++; $display("FAIL done_blank: got %b want 110", blank_digit); end
    tick(1);
    total++; if ({cook_state, done_pulse} !== {3'd4, 1'b0}) begin bad++; $display("FAIL done_once: got %0d/%b want 4/0", cook_state, done_pulse); end
    press_key(5);
    total++; if ({cook_state, sec_ones_segs} !== {3'd0, SEG[0]}) begin bad++; $display("FAIL done_key: got %0d/%h want 0/3f", cook_state, sec_ones_segs); end
    pulse_start;
    total++; if (cook_state !== 3'd0) begin bad++; $display("FAIL start_zero: got %0d want 0", cook_state); end
  endtask
  task automatic test_pause_resume;
    press_key(1);
    press_key(0);
    pulse_start;
    tick(5);
    door_closed = 1'b0;
    tick(1);
    total++; if ({cook_state, mag_on} !== {3'd2, 1'b1}) begin bad++; $display("FAIL door_lag: got %0d/%b want 2/1", cook_state, mag_on); end
    tick(1);
    total++; if ({cook_state, mag_on} !== {3'd3, 1'b0}) begin bad++; $display("FAIL door_pause: got %0d/%b want 3/0", cook_state, mag_on); end
    tick(4);
    total++; if (disp !== {7'h00, SEG[1], SEG[0]}) begin bad++; $display("FAIL pause_010: got %h want %h", disp, {7'h00, SEG[1], SEG[0]}); end
    door_closed = 1'b1;
    pulse_start;
    total++; if ({cook_state, mag_on} !== {3'd2, 1'b1}) begin bad++; $display("FAIL resume: got %0d/%b want 2/1", cook_state, mag_on); end
    tick(CLK - 7);
    total++; if (disp !== {7'h00, SEG[1], SEG[0]}) begin bad++; $display("FAIL resume_hold: got %h want %h", disp, {7'h00, SEG[1], SEG[0]}); end
    tick(1);
    total++; if (disp !== {7'h00, 7'h00, SEG[9]}) begin bad++; $display("FAIL resume_tick: got %h want %h", disp, {7'h00, 7'h00, SEG[9]}); end
    pulse_clear;
    press_key(1);
    press_key(0);
    press_key(0);
    pulse_start;
    tick(CLK - 1);
    total++; if (disp !== {SEG[1], SEG[0], SEG[0]}) begin bad++; $display("FAIL pre_borrow: got %h want %h", disp, {SEG[1], SEG[0], SEG[0]}); end
    tick(1);
    total++; if ({blank_digit, disp} !== {3'b100, 7'h00, SEG[5], SEG[9]}) begin bad++; $display("FAIL borrow_059: got %b/%h want 100/%h", blank_digit, disp, {7'h00, SEG[5], SEG[9]}); end
    pulse_clear;
    press_key(7);
    press_key(0);
    pulse_start;
    tick(CLK);
    total++; if (disp !== {7'h00, SEG[6], SEG[9]}) begin bad++; $display("FAIL tens7: got %h want %h", disp, {7'h00, SEG[6], SEG[9]}); end
    pulse_clear;
  endtask
`ifdef POWER_LEVEL_EN
  task automatic test_power;
    int on_cnt;
    on_cnt = 0;
    power_key = 1'b1;
    tick(2);
    power_key = 1'b0;
    tick(1);
    press_key(3);
    press_key(2);
    press_key(0);
    total++; if (disp !== {7'h00, SEG[2], SEG[0]}) begin bad++; $display("FAIL power_entry: got %h want %h", disp, {7'h00, SEG[2], SEG[0]}); end
    pulse_start;
    for (int i = 0; i < 10 * CLK; i++) begin
      on_cnt += int'(mag_on);
      tick(1);
    end
    total++; if (on_cnt !== 3 * CLK) begin bad++; $display("FAIL power_duty: got %0d want %0d", on_cnt, 3 * CLK); end
    pulse_clear;
  endtask
`endif
  initial begin
    test_reset;
    test_countdown;
    test_stop_clear;
    test_bad_keys;
    test_door_done;
    test_pause_resume;
`ifdef POWER_LEVEL_EN
    test_power;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
